// File: rtl/addsub_multicycle_pkg.sv
// Shared types for the multi-cycle adder-subtractor: FSM states, the NZCV
// flag bundle and the bit positions used when flags are packed into a nibble.
package addsub_multicycle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    // ARM-style condition flags, MSB first so the packed value reads NZCV
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    localparam int FLAG_N_BIT = 3;
    localparam int FLAG_Z_BIT = 2;
    localparam int FLAG_C_BIT = 1;
    localparam int FLAG_V_BIT = 0;

    // Assemble a flag bundle from its four components
    function automatic alu_flags_t make_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        alu_flags_t f;
        f.n = n;
        f.z = z;
        f.c = c;
        f.v = v;
        return f;
    endfunction

endpackage

// File: rtl/addsub_multicycle_if.sv
// Request/response bundle between execute-stage control and the adder.
interface addsub_multicycle_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  ready, done, result, negative, zero, carry_out, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output ready, done, result, negative, zero, carry_out, overflow
    );
endinterface

// File: rtl/addsub_multicycle_chunk.sv
// One CHUNK-wide slice of the adder; the FSM wrapper reuses it every cycle.
module add_sub_chunk #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] full_s;

    // One bit wider than the slice so the carry out is captured
    always_comb begin
        full_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

    assign sum  = full_s[W-1:0];
    assign cout = full_s[W];
endmodule

// File: rtl/addsub_multicycle.sv
// Multi-cycle WIDTH-bit adder-subtractor producing ARM NZCV flags. One CHUNK
// is added per cycle with the inter-chunk carry held in a register, keeping
// the critical path at a CHUNK-bit adder.
module addsub_multicycle
    import addsub_multicycle_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    addsub_multicycle_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    addsub_state_t    state_r;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;      // already inverted for subtraction
    logic             carry_r;
    logic [IDXW-1:0]  idx_r;
    logic             zacc_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] result_r;
    alu_flags_t       flags_r;
    logic             ready_r;
    logic             done_r;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK-1:0] chunk_sum_s;
    logic             chunk_cout_s;
    logic [WIDTH-1:0] result_next_s;
    alu_flags_t       flags_next_s;
    logic             last_s;

    // Select the operand slices for the chunk currently being processed
    always_comb begin
        a_chunk_s = op_a_r[idx_r*CHUNK +: CHUNK];
        b_chunk_s = op_b_r[idx_r*CHUNK +: CHUNK];
    end

    add_sub_chunk #(.W(CHUNK)) u_chunk (
        .a    (a_chunk_s),
        .b    (b_chunk_s),
        .cin  (carry_r),
        .sum  (chunk_sum_s),
        .cout (chunk_cout_s)
    );

    // Final result and flags as they will look once the top chunk is in
    always_comb begin
        last_s        = (idx_r == LAST_IDX);
        result_next_s = acc_r;
        result_next_s[(NCHUNK-1)*CHUNK +: CHUNK] = chunk_sum_s;
        flags_next_s  = make_flags(
            chunk_sum_s[CHUNK-1],
            zacc_r & (chunk_sum_s == {CHUNK{1'b0}}),
            chunk_cout_s,
            (op_a_r[WIDTH-1] == op_b_r[WIDTH-1]) &&
                (chunk_sum_s[CHUNK-1] != op_a_r[WIDTH-1]));
    end

    // Control FSM with datapath registers; outputs only move at RUN->DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            op_a_r   <= {WIDTH{1'b0}};
            op_b_r   <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            idx_r    <= {IDXW{1'b0}};
            zacc_r   <= 1'b0;
            acc_r    <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            flags_r  <= make_flags(1'b0, 1'b0, 1'b0, 1'b0);
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op_a_r  <= bus.a;
                        op_b_r  <= bus.b ^ {WIDTH{bus.sub}};
                        carry_r <= bus.sub;
                        idx_r   <= {IDXW{1'b0}};
                        zacc_r  <= 1'b1;
                        ready_r <= 1'b0;
                        state_r <= RUN;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    acc_r[idx_r*CHUNK +: CHUNK] <= chunk_sum_s;
                    carry_r <= chunk_cout_s;
                    zacc_r  <= zacc_r & (chunk_sum_s == {CHUNK{1'b0}});
                    idx_r   <= idx_r + IDX_ONE;
                    if (last_s) begin
                        result_r <= result_next_s;
                        flags_r  <= flags_next_s;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        done_r   <= 1'b0;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.negative  = flags_r.n;
    assign bus.zero      = flags_r.z;
    assign bus.carry_out = flags_r.c;
    assign bus.overflow  = flags_r.v;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Self-checking bench for addsub_multicycle (WIDTH=64, CHUNK=16).
module tb_addsub_multicycle;
    localparam int WIDTH  = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = WIDTH / CHUNK;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             n;
        logic             z;
        logic             c;
        logic             v;
    } exp_t;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;
    exp_t sb[$];

    addsub_multicycle_if #(.WIDTH(WIDTH)) bus ();

    addsub_multicycle #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width two's-complement add with flags
    function automatic exp_t model(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic sub);
        exp_t             e;
        logic [WIDTH-1:0] beff;
        logic [WIDTH:0]   s;
        beff  = sub ? ~b : b;
        s     = {1'b0, a} + {1'b0, beff} + {{WIDTH{1'b0}}, sub};
        e.res = s[WIDTH-1:0];
        e.c   = s[WIDTH];
        e.n   = s[WIDTH-1];
        e.z   = (s[WIDTH-1:0] == {WIDTH{1'b0}});
        e.v   = (a[WIDTH-1] == beff[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // Present one start request for one cycle, then scramble the operands
    task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic sub, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        if (push) sb.push_back(model(a, b, sub));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.sub   = ~sub;
    endtask

    // Wait (bounded) for done; lat counts falling edges since the start edge
    task automatic wait_done(input int lat_in, output int lat, output bit seen);
        lat = lat_in;
        while (bus.done !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        seen = (bus.done === 1'b1);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = {WIDTH{1'b0}};
        bus.b     = {WIDTH{1'b0}};
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.ready, bus.done} !== 2'b10) begin
            errors++;
            $display("FAIL reset_hs: ready/done=%b expected 10", {bus.ready, bus.done});
        end
        checks++;
        if ({bus.result, bus.negative, bus.zero, bus.carry_out, bus.overflow} !== {WIDTH+4{1'b0}}) begin
            errors++;
            $display("FAIL reset_out: result=%h nzcv=%b expected 0", bus.result,
                     {bus.negative, bus.zero, bus.carry_out, bus.overflow});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_ops();
        logic [WIDTH-1:0] ta[10];
        logic [WIDTH-1:0] tb_[10];
        logic             ts[10];
        int               lat;
        bit               seen;
        exp_t             e;
        ta[0] = 64'd5;                  tb_[0] = 64'd3; ts[0] = 1'b0;
        ta[1] = 64'd3;                  tb_[1] = 64'd5; ts[1] = 1'b1;
        ta[2] = 64'd7;                  tb_[2] = 64'd7; ts[2] = 1'b1;
        ta[3] = 64'h7FFF_FFFF_FFFF_FFFF; tb_[3] = 64'd1; ts[3] = 1'b0;
        ta[4] = 64'hFFFF_FFFF_FFFF_FFFF; tb_[4] = 64'd1; ts[4] = 1'b0;
        ta[5] = 64'h0000_0000_FFFF_FFFF; tb_[5] = 64'd1; ts[5] = 1'b0;
        ta[6] = 64'h8000_0000_0000_0000; tb_[6] = 64'd1; ts[6] = 1'b1;
        for (int i = 7; i < 10; i++) begin
            ta[i]  = {$urandom, $urandom};
            tb_[i] = {$urandom, $urandom};
            ts[i]  = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 10; i++) begin
            drive_start(ta[i], tb_[i], ts[i], 1'b1);
            wait_done(1, lat, seen);
            e = sb.pop_front();
            checks++;
            if (!seen || lat != NCHUNK + 1) begin
                errors++;
                $display("FAIL basic_latency[%0d]: seen=%0d lat=%0d expected %0d", i, seen, lat, NCHUNK + 1);
            end
            checks++;
            if (bus.result !== e.res) begin
                errors++;
                $display("FAIL basic_result[%0d]: got %h expected %h", i, bus.result, e.res);
            end
            checks++;
            if ({bus.negative, bus.zero, bus.carry_out, bus.overflow} !== {e.n, e.z, e.c, e.v}) begin
                errors++;
                $display("FAIL basic_nzcv[%0d]: got %b expected %b", i,
                         {bus.negative, bus.zero, bus.carry_out, bus.overflow}, {e.n, e.z, e.c, e.v});
            end
            @(negedge clk);
            checks++;
            if ({bus.ready, bus.done} !== 2'b10) begin
                errors++;
                $display("FAIL basic_after[%0d]: ready/done=%b expected 10", i, {bus.ready, bus.done});
            end
        end
    endtask

    task automatic test_handshake();
        int   dones;
        exp_t e;
        drive_start(64'd10, 64'd2, 1'b0, 1'b1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 64'd1;
        bus.b     = 64'd1;
        bus.sub   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        e = sb.pop_front();
        for (int c = 0; c < 14; c++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL hs_pulses: got %0d done pulses expected 1", dones);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.result !== e.res || bus.result !== 64'd12 || bus.ready !== 1'b1) begin
                errors++;
                $display("FAIL hs_hold[%0d]: result=%h ready=%b expected 12/1", c, bus.result, bus.ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midop();
        int   dones;
        int   lat;
        bit   seen;
        exp_t e;
        drive_start(64'd5, 64'd9, 1'b1, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.ready, bus.done} !== 2'b10 ||
            {bus.result, bus.negative, bus.zero, bus.carry_out, bus.overflow} !== {WIDTH+4{1'b0}}) begin
            errors++;
            $display("FAIL rst_async: ready/done=%b result=%h nzcv=%b expected 10/0/0",
                     {bus.ready, bus.done}, bus.result,
                     {bus.negative, bus.zero, bus.carry_out, bus.overflow});
        end
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL rst_nodone: got %0d done pulses expected 0", dones);
        end
        drive_start(64'd2, 64'd2, 1'b0, 1'b1);
        wait_done(1, lat, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || bus.result !== e.res || bus.result !== 64'd4) begin
            errors++;
            $display("FAIL rst_recover: seen=%0d result=%h expected 4", seen, bus.result);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int   cnt;
        int   last_cyc;
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 64'h0123_4567_89AB_CDEF;
        bus.b     = 64'h0FED_CBA9_8765_4321;
        bus.sub   = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back(model(bus.a, bus.b, bus.sub));
        cnt      = 0;
        last_cyc = 0;
        for (int cyc = 1; cyc < 40 && cnt < 3; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                e = sb.pop_front();
                checks++;
                if (bus.result !== e.res ||
                    {bus.negative, bus.zero, bus.carry_out, bus.overflow} !== {e.n, e.z, e.c, e.v}) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got %h/%b expected %h/%b", cnt, bus.result,
                             {bus.negative, bus.zero, bus.carry_out, bus.overflow}, e.res, {e.n, e.z, e.c, e.v});
                end
                if (cnt > 0) begin
                    checks++;
                    if (cyc - last_cyc != NCHUNK + 2) begin
                        errors++;
                        $display("FAIL b2b_gap[%0d]: got %0d expected %0d", cnt, cyc - last_cyc, NCHUNK + 2);
                    end
                end
                last_cyc = cyc;
                cnt++;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (cnt != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses expected 3", cnt);
        end
        sb.delete();
        repeat (NCHUNK + 3) @(negedge clk);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        test_reset();
        test_basic_ops();
        test_handshake();
        test_reset_midop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
